// File: rtl/rom_loader_receiver.sv
// rom_loader_receiver: receives words from an external ROM loader over a
// load/sck/data/ack handshake and turns each one into a memory write on a
// valid/ready port with an auto-incrementing address. The loader pins are
// asynchronous and pass through SYNC_STAGES-deep synchronizers.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add a modulo-2^DATA_WIDTH
// checksum output covering every word accepted in the current session.
module rom_loader_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_loader_load,
  input  logic                  rom_loader_sck,
  input  logic [DATA_WIDTH-1:0] rom_loader_data,
  output logic                  rom_loader_ack,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  loading,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WRITE, WAIT_LO} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   load_s;
  logic                   sck_s;
  logic                   load_s_prev;
  logic                   sck_s_prev;
  logic                   load_rise;
  logic                   sck_rise;
  logic                   start_sess;
  logic                   wr_fire;

  assign load_s     = load_sync[SYNC_STAGES-1];
  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign load_rise  = load_s & ~load_s_prev;
  assign sck_rise   = sck_s & ~sck_s_prev;
  assign start_sess = (state == IDLE) && load_rise;
  assign wr_fire    = (state == WRITE) && wr_valid && wr_ready;

  // Synchronize the asynchronous loader pins and keep last values for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_sync   <= '0;
      sck_sync    <= '0;
      load_s_prev <= 1'b0;
      sck_s_prev  <= 1'b0;
    end else begin
      load_sync[0] <= rom_loader_load;
      sck_sync[0]  <= rom_loader_sck;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        load_sync[i] <= load_sync[i-1];
        sck_sync[i]  <= sck_sync[i-1];
      end
      load_s_prev <= load_s;
      sck_s_prev  <= sck_s;
    end
  end

  // Session FSM with registered handshake, write-port and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rom_loader_ack <= 1'b0;
      wr_valid       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      loading        <= 1'b0;
      word_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // sck activity is ignored until a session opens
          if (start_sess) begin
            state      <= WAIT_HI;
            loading    <= 1'b1;
            wr_addr    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        WAIT_HI: begin
          // load falling wins over a coincident sck rise
          if (!load_s) begin
            state   <= IDLE;
            loading <= 1'b0;
          end else if (sck_rise) begin
            state    <= WRITE;
            wr_data  <= rom_loader_data;
            wr_valid <= 1'b1;
          end
        end
        WRITE: begin
          // a pending write is never withdrawn, even if the session ends
          if (wr_fire) begin
            wr_valid   <= 1'b0;
            wr_addr    <= wr_addr + ADDR_ONE;
            word_count <= word_count + ADDR_ONE;
            if (&wr_addr) begin
              overflow <= 1'b1;
            end
            if (load_s) begin
              state          <= WAIT_LO;
              rom_loader_ack <= 1'b1;
            end else begin
              state   <= IDLE;
              loading <= 1'b0;
            end
          end
        end
        WAIT_LO: begin
          if (!load_s) begin
            state          <= IDLE;
            loading        <= 1'b0;
            rom_loader_ack <= 1'b0;
          end else if (!sck_s) begin
            state          <= WAIT_HI;
            rom_loader_ack <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] wrap_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Running session checksum: cleared when a session opens, summed per accepted word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (start_sess) begin
      checksum <= '0;
    end else if (wr_fire) begin
      checksum <= wrap_add(checksum, wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_rom_loader_receiver.sv
// Testbench for rom_loader_receiver (ADDR_WIDTH=4 so that address wrap is reachable).
// Writes are checked by a monitor against a queue of expected {addr,data} pairs
// filled by the stimulus; ack pulses are counted by the monitor as well.
module tb_rom_loader_receiver;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rom_loader_load = 1'b0;
  logic          rom_loader_sck = 1'b0;
  logic [DW-1:0] rom_loader_data = '0;
  logic          rom_loader_ack;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          loading;
  logic [AW-1:0] word_count;
  logic          overflow;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rom_loader_receiver #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_loader_load(rom_loader_load),
    .rom_loader_sck (rom_loader_sck),
    .rom_loader_data(rom_loader_data),
    .rom_loader_ack (rom_loader_ack),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .loading        (loading),
    .word_count     (word_count),
    .overflow       (overflow)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            ack_seen = 0;
  int            exp_acks = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return rom_loader_ack;
      1:       return wr_valid;
      default: return loading;
    endcase
  endfunction

  // Wait (bounded) for a DUT output to reach a value; the final state is a comparison
  task automatic wait_for(input int w, input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (sel(w) !== v && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sel(w)), 32'(v));
  endtask

  task automatic start_session();
    rom_loader_load = 1'b1;
    exp_addr = '0;
    wait_for(2, 1'b1, 20, "loading_rise");
    check("word_count_cleared", 32'(word_count), 0);
    check("wr_addr_cleared", 32'(wr_addr), 0);
    check("overflow_cleared", 32'(overflow), 0);
  endtask

  task automatic end_session();
    rom_loader_load = 1'b0;
    wait_for(2, 1'b0, 20, "loading_fall");
  endtask

  // One complete word transfer; hold>0 keeps wr_ready low for that many cycles of wr_valid
  task automatic send_word(input logic [DW-1:0] d, input int hold);
    wr_ready = (hold == 0);
    rom_loader_data = d;
    exp_q.push_back(wr_t'{addr: exp_addr, data: d});
    exp_addr = exp_addr + 1'b1;
    tick();
    rom_loader_sck = 1'b1;
    if (hold > 0) begin
      wait_for(1, 1'b1, 20, "bp_valid_rise");
      repeat (hold) begin
        tick();
        check("bp_no_ack", 32'(rom_loader_ack), 0);
      end
      check("bp_valid_held", 32'(wr_valid), 1);
      wr_ready = 1'b1;
    end
    wait_for(0, 1'b1, 30, "ack_rise");
    exp_acks++;
    rom_loader_sck = 1'b0;
    wait_for(0, 1'b0, 30, "ack_fall");
  endtask

  // Monitor: compares every presented write with the queue head and counts ack pulses
  initial begin
    logic ack_prev;
    wr_t  e;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_prev = 1'b0;
      end else begin
        if (rom_loader_ack && !ack_prev) ack_seen++;
        ack_prev = rom_loader_ack;
        if (wr_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
          end else begin
            e = exp_q[0];
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
            if (wr_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_ack", 32'(rom_loader_ack), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_loading", 32'(loading), 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    repeat (3) tick();

    // Basic 3-word load
    start_session();
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h0000, 0);
    check("basic_word_count", 32'(word_count), 3);
    check("basic_loading", 32'(loading), 1);
    end_session();
    repeat (3) tick();
    check("basic_acks", 32'(ack_seen), 32'(exp_acks));
    check("retain_word_count", 32'(word_count), 3);
    check("retain_wr_addr", 32'(wr_addr), 3);
    check("basic_queue_empty", 32'(exp_q.size()), 0);

    // Backpressure on word 0
    start_session();
    send_word(16'h5A5A, 10);
    send_word(16'h00FF, 0);
    check("bp_word_count", 32'(word_count), 2);
    check("bp_acks", 32'(ack_seen), 32'(exp_acks));
    end_session();

    // Address wrap with ADDR_WIDTH=4
    start_session();
    for (int i = 0; i < 17; i++) begin
      send_word(16'(16'h0100 + i * 16'h0011), 0);
      if (i == 14) check("wrap_ovf_before", 32'(overflow), 0);
      if (i == 15) begin
        check("wrap_ovf_set", 32'(overflow), 1);
        check("wrap_count_zero", 32'(word_count), 0);
      end
    end
    check("wrap_overflow", 32'(overflow), 1);
    check("wrap_word_count", 32'(word_count), 1);
    check("wrap_wr_addr", 32'(wr_addr), 1);
    end_session();
    check("wrap_ovf_retained", 32'(overflow), 1);

    // Abort while the write is pending
    start_session();
    wr_ready = 1'b0;
    rom_loader_data = 16'hC0DE;
    exp_q.push_back(wr_t'{addr: exp_addr, data: 16'hC0DE});
    tick();
    rom_loader_sck = 1'b1;
    wait_for(1, 1'b1, 20, "abort_valid_rise");
    rom_loader_load = 1'b0;
    repeat (5) tick();
    check("abort_valid_held", 32'(wr_valid), 1);
    check("abort_loading_held", 32'(loading), 1);
    wr_ready = 1'b1;
    wait_for(2, 1'b0, 20, "abort_loading_fall");
    rom_loader_sck = 1'b0;
    repeat (5) tick();
    check("abort_word_count", 32'(word_count), 1);
    check("abort_valid_low", 32'(wr_valid), 0);
    check("abort_no_ack", 32'(ack_seen), 32'(exp_acks));
    // sck activity while idle must not produce a write
    rom_loader_sck = 1'b1;
    repeat (6) tick();
    rom_loader_sck = 1'b0;
    repeat (6) tick();
    check("idle_no_write_loading", 32'(loading), 0);
    check("abort_queue_empty", 32'(exp_q.size()), 0);

    // Reset in WAIT_LO
    start_session();
    send_word(16'h1111, 0);
    rom_loader_data = 16'hBEEF;
    exp_q.push_back(wr_t'{addr: exp_addr, data: 16'hBEEF});
    exp_addr = exp_addr + 1'b1;
    tick();
    rom_loader_sck = 1'b1;
    wait_for(0, 1'b1, 30, "mid_ack_rise");
    reset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(rom_loader_ack), 0);
    check("mid_rst_wr_valid", 32'(wr_valid), 0);
    check("mid_rst_wr_addr", 32'(wr_addr), 0);
    check("mid_rst_wr_data", 32'(wr_data), 0);
    check("mid_rst_loading", 32'(loading), 0);
    check("mid_rst_word_count", 32'(word_count), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    rom_loader_load = 1'b0;
    rom_loader_sck = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("post_rst_idle", 32'(loading), 0);
    start_session();
    send_word(16'h2222, 0);
    check("post_rst_count", 32'(word_count), 1);
    end_session();
    check("post_rst_queue_empty", 32'(exp_q.size()), 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum wraps modulo 2^16
    start_session();
    check("cksum_cleared", 32'(checksum), 0);
    send_word(16'hFFFF, 0);
    send_word(16'h0002, 0);
    check("cksum_value", 32'(checksum), 32'h0001);
    end_session();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
